// File: rtl/ula_pkg.sv
// Shared encodings for the ula_exec ALU execute unit: ALUOp/funct codes,
// the internal operation selector and the mult/div engine states.
package ula_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_PASSA, OP_MFHI, OP_MFLO, OP_MULDIV, OP_ILL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative sign-magnitude multiply (shift-add) and restoring divide engine.
// One step per RUN cycle; FIX applies signs and presents hi/lo with done=1.
module ula_muldiv_iter
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_e           state
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dz;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // r_acc holds the running high product word (mult) or partial remainder (div).
    assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_m};

    assign w_prod   = {r_acc, r_q};
    assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
    assign w_quo    = r_dz ? {WIDTH{1'b1}} : (r_neg_lo ? -r_q : r_q);
    assign w_rem    = r_neg_hi ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CW'(1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_cnt    <= CW'(WIDTH);
                r_acc    <= '0;
                r_q      <= w_a_mag;
                r_m      <= w_b_mag;
                r_is_div <= is_div;
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= is_div ? w_a_neg : (w_a_neg ^ w_b_neg);
                r_dz     <= is_div && (b == '0);
            end
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_is_div) begin
                if (!w_div_diff[WIDTH]) begin
                    r_acc <= w_div_diff[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_div_sh[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= w_mul_sum[WIDTH:1];
                r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_FIX);
    assign state = r_state;
    assign hi    = r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
    assign lo    = r_is_div ? w_quo : w_prod_s[WIDTH-1:0];

endmodule

// File: rtl/ula_exec.sv
// EX-stage ALU: decodes ALUOp/funct, computes single-cycle ops, owns HI/LO and
// a one-deep registered result; iterative mult/div is delegated to ula_muldiv_iter.
module ula_exec
    import ula_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUOp,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               jr,
    output logic               illegal,
    output logic               busy,
    output state_e             dbg_state
);

    op_e                w_op;
    logic               w_shvar, w_ovf_en, w_jr, w_set_hi, w_set_lo;
    logic               w_md_div, w_md_signed;
    logic               w_is_sub, w_ovf, w_accept, w_md_start;
    logic               w_busy, w_md_done;
    logic [WIDTH-1:0]   w_b_op, w_sum, w_res, w_md_hi, w_md_lo;
    logic [SHAMT_W-1:0] w_sh;

    logic [WIDTH-1:0]   r_hi, r_lo, r_result;
    logic               r_out_valid, r_zero, r_ovf, r_jr, r_illegal;

    always_comb begin
        w_op = OP_ILL;
        w_shvar = 1'b0; w_ovf_en = 1'b0; w_jr = 1'b0;
        w_set_hi = 1'b0; w_set_lo = 1'b0; w_md_div = 1'b0; w_md_signed = 1'b0;
        case (ALUOp)
            ALUOP_ADD: w_op = OP_ADD;
            ALUOP_SUB: w_op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   begin w_op = OP_ADD; w_ovf_en = 1'b1; end
                    F_ADDU:  w_op = OP_ADD;
                    F_SUB:   begin w_op = OP_SUB; w_ovf_en = 1'b1; end
                    F_SUBU:  w_op = OP_SUB;
                    F_AND:   w_op = OP_AND;
                    F_OR:    w_op = OP_OR;
                    F_XOR:   w_op = OP_XOR;
                    F_NOR:   w_op = OP_NOR;
                    F_SLT:   w_op = OP_SLT;
                    F_SLTU:  w_op = OP_SLTU;
                    F_SLL:   w_op = OP_SLL;
                    F_SRL:   w_op = OP_SRL;
                    F_SRA:   w_op = OP_SRA;
                    F_SLLV:  begin w_op = OP_SLL; w_shvar = 1'b1; end
                    F_SRLV:  begin w_op = OP_SRL; w_shvar = 1'b1; end
                    F_SRAV:  begin w_op = OP_SRA; w_shvar = 1'b1; end
                    F_JR:    begin w_op = OP_PASSA; w_jr = 1'b1; end
                    F_MFHI:  w_op = OP_MFHI;
                    F_MFLO:  w_op = OP_MFLO;
                    F_MTHI:  begin w_op = OP_PASSA; w_set_hi = 1'b1; end
                    F_MTLO:  begin w_op = OP_PASSA; w_set_lo = 1'b1; end
                    F_MULT:  begin w_op = OP_MULDIV; w_md_signed = 1'b1; end
                    F_MULTU: w_op = OP_MULDIV;
                    F_DIV:   begin w_op = OP_MULDIV; w_md_div = 1'b1; w_md_signed = 1'b1; end
                    F_DIVU:  begin w_op = OP_MULDIV; w_md_div = 1'b1; end
                    default: w_op = OP_ILL;
                endcase
            end
            default: w_op = OP_ILL;
        endcase
    end

    // Subtraction reuses the adder as a + ~b + 1; overflow compares against the
    // effective second operand so ADD and SUB share one rule.
    assign w_is_sub = (w_op == OP_SUB);
    assign w_b_op   = w_is_sub ? ~b : b;
    assign w_sum    = a + w_b_op + {{(WIDTH-1){1'b0}}, w_is_sub};
    assign w_ovf    = w_ovf_en && (a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sh     = w_shvar ? a[SHAMT_W-1:0] : shamt;

    always_comb begin
        w_res = '0;
        case (w_op)
            OP_ADD, OP_SUB: w_res = w_sum;
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_XOR:   w_res = a ^ b;
            OP_NOR:   w_res = ~(a | b);
            OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:   w_res = b << w_sh;
            OP_SRL:   w_res = b >> w_sh;
            OP_SRA:   w_res = $unsigned($signed(b) >>> w_sh);
            OP_PASSA: w_res = a;
            OP_MFHI:  w_res = r_hi;
            OP_MFLO:  w_res = r_lo;
            default:  w_res = '0;
        endcase
    end

    // Handshake: a beat transfers on a rising edge where valid&ready are both high.
    // The input side only accepts while the engine is idle and the result slot is
    // empty or being drained on that same edge.
    assign w_accept   = in_valid && in_ready;
    assign w_md_start = w_accept && (w_op == OP_MULDIV);
    assign in_ready   = !w_busy && (!r_out_valid || out_ready);

    ula_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_md_start),
        .is_div    (w_md_div),
        .is_signed (w_md_signed),
        .a         (a),
        .b         (b),
        .busy      (w_busy),
        .done      (w_md_done),
        .hi        (w_md_hi),
        .lo        (w_md_lo),
        .state     (dbg_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0; r_lo <= '0; r_result <= '0;
            r_out_valid <= 1'b0; r_zero <= 1'b0; r_ovf <= 1'b0;
            r_jr <= 1'b0; r_illegal <= 1'b0;
        end else if (w_md_done) begin
            r_hi        <= w_md_hi;
            r_lo        <= w_md_lo;
            r_result    <= w_md_lo;
            r_zero      <= (w_md_lo == '0);
            r_ovf       <= 1'b0;
            r_jr        <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_accept && (w_op != OP_MULDIV)) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_jr        <= w_jr;
            r_illegal   <= (w_op == OP_ILL);
            r_out_valid <= 1'b1;
            if (w_set_hi) r_hi <= a;
            if (w_set_lo) r_lo <= a;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign jr        = r_jr;
    assign illegal   = r_illegal;
    assign busy      = w_busy;

endmodule

// File: tb/tb_ula_exec.sv
// Bench for ula_exec: directed scenarios plus randomized ops with backpressure,
// scored against a behavioural model using wide integer arithmetic.
module tb_ula_exec;
  import ula_pkg::*;

  localparam int W = 32;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B, FN_ADD = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [5:0] fn_tab [25] = '{FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
                              FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV,
                              FN_DIVU, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                              FN_XOR, FN_NOR, FN_SLT, FN_SLTU};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   ALUOp = 2'b00;
  logic [5:0]   funct = 6'h00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   shamt = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, ovf, jr, illegal, busy;
  state_e       dbg_state;

  ula_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovf(ovf), .jr(jr), .illegal(illegal), .busy(busy),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [W+3:0] exp_q[$];
  logic [W+3:0] mon_e;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  bit bp_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: expected {illegal, jr, ovf, zero, result} per accepted op
  task automatic model_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] av, input logic [W-1:0] bv, input logic [4:0] sh);
    logic [W-1:0] r;
    logic ov, j, il;
    longint sa, sb, s, q, rm;
    logic [63:0] p;
    r = '0; ov = 1'b0; j = 1'b0; il = 1'b0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (op)
      2'b00: r = av + bv;
      2'b01: r = av - bv;
      2'b11: il = 1'b1;
      default: begin
        case (fn)
          FN_ADD:  begin r = av + bv; s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          FN_ADDU: r = av + bv;
          FN_SUB:  begin r = av - bv; s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          FN_SUBU: r = av - bv;
          FN_AND:  r = av & bv;
          FN_OR:   r = av | bv;
          FN_XOR:  r = av ^ bv;
          FN_NOR:  r = ~(av | bv);
          FN_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
          FN_SLTU: r = (av < bv) ? 32'd1 : 32'd0;
          FN_SLL:  r = bv << sh;
          FN_SRL:  r = bv >> sh;
          FN_SRA:  r = $signed(bv) >>> sh;
          FN_SLLV: r = bv << av[4:0];
          FN_SRLV: r = bv >> av[4:0];
          FN_SRAV: r = $signed(bv) >>> av[4:0];
          FN_JR:   begin r = av; j = 1'b1; end
          FN_MFHI: r = m_hi;
          FN_MFLO: r = m_lo;
          FN_MTHI: begin m_hi = av; r = av; end
          FN_MTLO: begin m_lo = av; r = av; end
          FN_MULT, FN_MULTU: begin
            if (fn == FN_MULT) p = sa * sb;
            else p = {32'h0, av} * {32'h0, bv};
            m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo;
          end
          FN_DIV: begin
            if (bv == '0) begin m_lo = '1; m_hi = av; end
            else begin q = sa / sb; rm = sa % sb; m_lo = 32'(q); m_hi = 32'(rm); end
            r = m_lo;
          end
          FN_DIVU: begin
            if (bv == '0) begin m_lo = '1; m_hi = av; end
            else begin m_lo = av / bv; m_hi = av % bv; end
            r = m_lo;
          end
          default: il = 1'b1;
        endcase
      end
    endcase
    exp_q.push_back({il, j, ov, (r == '0), r});
  endtask

  // driver: offer one op, wait (bounded) for in_ready, log it in the model on acceptance
  task automatic send_op(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] av, input logic [W-1:0] bv, input logic [4:0] sh);
    int waited;
    waited = 0;
    ALUOp = op; funct = fn; a = av; b = bv; shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check_eq("accept_wait", in_ready, 1'b1);
    @(posedge clk);
    if (waited < 200) model_op(op, fn, av, bv, sh);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input string tag, input logic [1:0] op, input logic [5:0] fn,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] exp_res);
    send_op(op, fn, av, bv, 5'd0);
    check_eq(tag, result, exp_res);
  endtask

  // scoreboard: every consumed beat must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check_eq("beat_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("sb_result", result, mon_e[W-1:0]);
        check_eq("sb_flags", {illegal, jr, ovf, zero}, mon_e[W+3:W]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int d;
    logic [1:0] op;
    logic [5:0] fn;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_flags", {zero, ovf, jr, illegal}, 4'b0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // signed ADD overflow, single-cycle beat
    send_op(2'b10, FN_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check_eq("add_valid", out_valid, 1'b1);
    check_eq("add_result", result, 32'h8000_0000);
    check_eq("add_ovf", ovf, 1'b1);
    check_eq("add_zero", zero, 1'b0);
    @(posedge clk);
    #1;
    check_eq("add_valid_drop", out_valid, 1'b0);

    // MULT latency, busy/in_ready while iterating
    send_op(2'b10, FN_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
    check_eq("mult_busy0", busy, 1'b1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid) begin
        check_eq("mult_busy", busy, 1'b1);
        check_eq("mult_in_ready", in_ready, 1'b0);
      end
    end while (!out_valid && lat < 40);
    check_eq("mult_latency", lat, W + 1);
    check_eq("mult_result", result, 32'hFFFF_FFEB);
    send_expect("mfhi_mult", 2'b10, FN_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);
    send_expect("mflo_mult", 2'b10, FN_MFLO, 32'h0, 32'h0, 32'hFFFF_FFEB);

    // divides, including divide by zero
    send_op(2'b10, FN_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    send_expect("div_lo", 2'b10, FN_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFD);
    send_expect("div_hi", 2'b10, FN_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);
    send_op(2'b10, FN_DIVU, 32'd100, 32'd7, 5'd0);
    send_expect("divu_lo", 2'b10, FN_MFLO, 32'h0, 32'h0, 32'd14);
    send_expect("divu_hi", 2'b10, FN_MFHI, 32'h0, 32'h0, 32'd2);
    send_op(2'b10, FN_DIVU, 32'd5, 32'd0, 5'd0);
    send_expect("div0_lo", 2'b10, FN_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF);
    send_expect("div0_hi", 2'b10, FN_MFHI, 32'h0, 32'h0, 32'd5);

    // decode edges
    send_expect("ill_aluop", 2'b11, FN_ADD, 32'h1234, 32'h5678, 32'h0);
    check_eq("ill_aluop_flag", illegal, 1'b1);
    send_expect("ill_funct", 2'b10, 6'h3F, 32'h1234, 32'h5678, 32'h0);
    check_eq("ill_funct_flag", illegal, 1'b1);
    send_expect("jr_result", 2'b10, FN_JR, 32'h400, 32'h9, 32'h400);
    check_eq("jr_flag", jr, 1'b1);
    send_expect("srav", 2'b10, FN_SRAV, 32'h24, 32'h8000_0000, 32'hF800_0000);

    // backpressure: hold, then consume and accept on the same edge
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_op(2'b01, 6'h00, 32'd9, 32'd9, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_result", result, 32'h0);
      check_eq("bp_zero", zero, 1'b1);
      check_eq("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_expect("bp_next", 2'b10, FN_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    check_eq("bp_next_valid", out_valid, 1'b1);

    // reset in the middle of a MULTU
    send_op(2'b10, FN_MULTU, $urandom, $urandom, 5'd0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_out_valid", out_valid, 1'b0);
    check_eq("mrst_result", result, 32'h0);
    check_eq("mrst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_expect("mrst_mflo", 2'b10, FN_MFLO, 32'h0, 32'h0, 32'h0);
    send_expect("mrst_mfhi", 2'b10, FN_MFHI, 32'h0, 32'h0, 32'h0);
    send_op(2'b10, FN_MULTU, 32'd3, 32'd4, 5'd0);
    send_expect("mrst_multu", 2'b10, FN_MFLO, 32'h0, 32'h0, 32'd12);

    // randomized traffic with random consumer backpressure
    bp_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, 99);
      if (d < 5) op = 2'b00;
      else if (d < 10) op = 2'b01;
      else if (d < 13) op = 2'b11;
      else op = 2'b10;
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
      else fn = fn_tab[$urandom_range(0, 24)];
      send_op(op, fn, rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));
    end
    bp_mode = 1'b0;
    out_ready = 1'b1;

    d = 0;
    while (exp_q.size() != 0 && d < 500) begin
      @(posedge clk);
      d++;
    end
    @(posedge clk);
    #1;
    check_eq("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_exec.md
Name: ula_exec

Overview:
Parametrised ALU execute unit that decodes ALUOp/funct internally. It drives a registered result through a valid/ready handshake and adds HI/LO register state. It includes an iterative multiply/divide engine covering MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. It sits in EX between operand forwarding and the EX/MEM register; in_ready low is the pipeline stall source.

Parameters:
WIDTH, 32, datapath width in bits (even, >=8)
SHAMT_W, $clog2(WIDTH), shift-amount width

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid&in_ready at posedge
ALUOp  in  2  00 add, 01 sub, 10 R-type (funct), 11 illegal
funct  in  6  R-type function field
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand / immediate
shamt  in  SHAMT_W  constant shift amount
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer takes result at posedge when out_valid&out_ready
result  out  WIDTH  registered result
zero  out  1  result==0, registered with result
ovf  out  1  signed overflow for R-type ADD/SUB only
jr  out  1  op was JR (result=a)
illegal  out  1  undecoded ALUOp/funct (result=0)
busy  out  1  mult/div engine not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, HI=LO=0, out_valid=0, result=0, zero=0, ovf=0, jr=0, illegal=0, busy=0. Applies mid-iteration; partial product/quotient is discarded.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops: on the accept edge, result and flags are loaded and out_valid=1 (visible the next cycle).
  - ADD/SUB/AND/OR/XOR/NOR: usual definitions, mod 2^WIDTH.
  - SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0, zero-extended.
  - SLL/SRL/SRA: b shifted by shamt.
  - SLLV/SRLV/SRAV: b shifted by a[SHAMT_W-1:0].
  - JR: result=a, jr=1.
  - MFHI/MFLO: result=HI/LO.
  - MTHI/MTLO: HI/LO=a, result=a.
- ovf: sign(a)==sign(op-b) && sign(sum)!=sign(a). It is flag-only; result is still written.
- Funct encodings are the MIPS-I values. Mult/div: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- Mult/div FSM (IDLE -> RUN -> FIX -> IDLE):
  - IDLE: accept latches |a|, |b| (signed ops) or raw (unsigned ops), records the result signs, cnt=WIDTH, -> RUN; busy=1.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle; cnt decrements; at cnt==1 -> FIX.
  - FIX: applies sign correction and writes {HI,LO}. Mult: HI:LO = 2*WIDTH product. Div: LO=quotient, HI=remainder, remainder sign = sign(a). Loads result=LO and out_valid=1, -> IDLE.
  - out_valid rises WIDTH+1 edges after the accepting edge.
- Divide by zero: no trap. LO=all-ones, HI=a, same latency.
- Output register holds result and flags stable while out_valid&!out_ready.
- Same-edge consume and accept is allowed (out_ready=1 frees the slot).
- MFHI/MFLO cannot race a running op, because in_ready=0 outside IDLE.

Decomposition:
- Package ula_pkg: ALUOp constants, funct localparams (incl. mult/div/HI/LO), 4-bit internal op enum, FSM state enum.
- One sub-module: ula_muldiv_iter (RUN/FIX iteration, WIDTH parameter, start/done pulse, outputs hi/lo). The top holds decode, single-cycle datapath, HI/LO, output register and handshake.

Test Plan:
- ADD a=0x7FFFFFFF b=1 (ALUOp=10, funct=100000), out_ready=1 -> next cycle result=0x80000000, ovf=1, zero=0, out_valid=1 for one cycle.
- MULT a=0xFFFFFFFD b=7, then MFHI, MFLO -> done result=0xFFFFFFEB 33 edges after accept; busy=1 and in_ready=0 throughout; MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB.
- DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- Backpressure: SUB 9-9 with out_ready=0 for 3 cycles -> result=0, zero=1 held stable, in_ready=0. Release with new op on the same edge -> new op accepted, no lost beat.
- Reset mid-RUN (rst_n low at iteration 10 of MULTU) -> outputs/HI/LO=0 immediately; after release, MFLO returns 0 and a fresh MULTU 3*4 gives LO=12.
- Decode edges: ALUOp=11 or funct=111111 -> illegal=1, result=0. JR a=0x400 -> jr=1, result=0x400. SRAV b=0x80000000 a=0x24 -> 0xF8000000 (shift 4).
